// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO between uart_rx and the byte consumer, with sticky overrun.
// Optional almost_full flag is enabled by defining RX_FIFO_AF_EN.
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              almost_full
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              overrun_reg;
    logic              rd_fire;
    logic              wr_accept;
    logic              wr_drop;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    always_comb begin
        rd_fire    = (count_reg != '0) && rd_ready;
        wr_accept  = wr_valid && ((count_reg != DEPTH_C) || rd_fire);
        wr_drop    = wr_valid && !wr_accept;
        count_next = count_reg;
        case ({wr_accept, rd_fire})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (rd_fire)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg <= count_next;
            // Setting on a fresh drop outranks a simultaneous clear.
            if (wr_drop)      overrun_reg <= 1'b1;
            else if (ovr_clr) overrun_reg <= 1'b0;
        end
    end

    // Storage is not reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) mem[wr_ptr_reg] <= wr_data;
    end

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == DEPTH_C);
    assign count    = count_reg;
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
    assign overrun  = overrun_reg;

`ifdef RX_FIFO_AF_EN
    logic almost_full_reg;

    // Compare against the next count so the flag rises on the same edge count does.
    always_ff @(posedge clk) begin
        if (rst) almost_full_reg <= 1'b0;
        else     almost_full_reg <= (count_next >= (ADDR_W + 1)'(AF_LEVEL));
    end

    assign almost_full = almost_full_reg;
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: vector table plus hand sequences
// for full-with-pop, set/clear priority, wrapping stream and almost_full.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overrun;
    logic       ovr_clr = 1'b0;
    logic       almost_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .AF_LEVEL(12)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .count(count), .full(full), .empty(empty), .overrun(overrun),
        .ovr_clr(ovr_clr), .almost_full(almost_full)
    );

    typedef struct {
        logic       rst;
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       oc;
        logic       rv;
        logic [7:0] rd;
        int         cnt;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic exp_af(input int cnt);
`ifdef RX_FIFO_AF_EN
        return cnt >= 12;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic void add(input logic r, input logic wv, input logic [7:0] wd,
                                input logic rr, input logic oc, input logic rv,
                                input logic [7:0] rd, input int cnt, input logic ovr);
        vec_t v;
        v.rst = r; v.wv = wv; v.wd = wd; v.rr = rr; v.oc = oc;
        v.rv = rv; v.rd = rd; v.cnt = cnt; v.ovr = ovr;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic wv, input logic [7:0] wd,
                         input logic rr, input logic oc);
        rst = r; wr_valid = wv; wr_data = wd; rd_ready = rr; ovr_clr = oc;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; ovr_clr = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic rv, input logic [7:0] rd,
                               input int cnt, input logic ovr);
        check({tag, " rd_valid"}, int'(rd_valid), int'(rv));
        check({tag, " rd_data"}, int'(rd_data), int'(rd));
        check({tag, " count"}, int'(count), cnt);
        check({tag, " full"}, int'(full), int'(cnt == 16));
        check({tag, " empty"}, int'(empty), int'(cnt == 0));
        check({tag, " overrun"}, int'(overrun), int'(ovr));
        check({tag, " almost_full"}, int'(almost_full), int'(exp_af(cnt)));
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, base + 8'(i), 1'b0, 1'b0);
    endtask

    initial begin
        // Reset, single byte, pop, ignored read while empty.
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        // Fill 0x01..0x10, head stays 0x01.
        for (int i = 1; i <= 16; i++) add(0, 1, 8'(i), 0, 0, 1, 8'h01, i, 0);
        // 17th byte dropped.
        add(0, 1, 8'h55, 0, 0, 1, 8'h01, 16, 1);
        // Drain in order; overrun stays sticky.
        for (int k = 1; k <= 16; k++)
            add(0, 0, 8'h00, 1, 0, k < 16, (k < 16) ? 8'(k + 1) : 8'h00, 16 - k, 1);
        add(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // Write into empty with rd_ready high: no read happens.
        add(0, 1, 8'h99, 1, 0, 1, 8'h99, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        // Five bytes then reset together with a write: everything discarded.
        for (int i = 0; i < 5; i++) add(0, 1, 8'h61 + 8'(i), 0, 0, 1, 8'h61, i + 1, 0);
        add(1, 1, 8'hEE, 0, 0, 0, 8'h00, 0, 0);
        add(0, 1, 8'h3C, 0, 0, 1, 8'h3C, 1, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].oc);
            check_state($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rd, vecs[i].cnt, vecs[i].ovr);
        end

        // Full FIFO with simultaneous write and read: 0x77 must come out last.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        fill(8'h80);
        check_state("full_pre", 1'b1, 8'h80, 16, 1'b0);
        drive(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        check_state("full_wr_rd", 1'b1, 8'h81, 16, 1'b0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("full_drain%0d data", k), int'(rd_data),
                  (k < 15) ? 32'h81 + k : 32'h77);
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_state("full_drained", 1'b0, 8'h00, 0, 1'b0);

        // Drop and clear in the same cycle: set wins.
        fill(8'hC0);
        drive(1'b0, 1'b1, 8'hDD, 1'b0, 1'b1);
        check_state("set_vs_clr", 1'b1, 8'hC0, 16, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_state("clr_only", 1'b1, 8'hC0, 16, 1'b0);

        // Continuous stream of 40 bytes, both pointers wrap twice.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
            check($sformatf("stream%0d data", i), int'(rd_data), i);
            check($sformatf("stream%0d count", i), int'(count), 1);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_state("stream_end", 1'b0, 8'h00, 0, 1'b0);

        // Almost-full threshold walk.
        for (int i = 1; i <= 12; i++) begin
            drive(1'b0, 1'b1, 8'hF0 + 8'(i), 1'b0, 1'b0);
            check($sformatf("af_wr%0d", i), int'(almost_full), int'(exp_af(i)));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("af_after_read", int'(almost_full), 0);
        check("af_after_read count", int'(count), 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
